// File: rtl/cop0_hw_writer.sv
// cop0_hw_writer: hardware-side CP0 update sequencer.
// Drives exception entry, ERET and interrupt-pending updates through the
// single masked CP0 write port, one register per cycle.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no sequence; arbitrate exc > eret > IP update
// W_BVA     | write BadVAddr (8/0) with the faulting address
// W_EPC     | write EPC (14/0); skipped when EXL was already set
// W_CAUSE   | write Cause BD/ExcCode (13/0); BD left alone when EXL set
// W_STATUS  | set Status.EXL (12/0)
// EXC_ACK   | exc_ack pulse, no write
// W_ERET    | clear Status.ERL or Status.EXL
// ERET_ACK  | eret_ack pulse, no write
// W_IP      | write Cause IP[7:2] from hw_irq, no ack
module cop0_hw_writer #(
  parameter int unsigned EPC_BD_OFFSET = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_bva_valid,
  input  logic [31:0] exc_bva,
  output logic        exc_ack,
  input  logic        eret_valid,
  output logic        eret_ack,
  input  logic [31:0] status_in,
  input  logic [31:0] cause_in,
  input  logic [5:0]  hw_irq,
  output logic        wr_en,
  output logic [4:0]  wr_rd,
  output logic [2:0]  wr_sel,
  output logic [31:0] wr_data,
  output logic [31:0] wr_mask,
  output logic        busy
);

  localparam logic [4:0] RD_BADVADDR = 5'd8;
  localparam logic [4:0] RD_STATUS   = 5'd12;
  localparam logic [4:0] RD_CAUSE    = 5'd13;
  localparam logic [4:0] RD_EPC      = 5'd14;

  typedef enum logic [3:0] {
    IDLE, W_BVA, W_EPC, W_CAUSE, W_STATUS, EXC_ACK, W_ERET, ERET_ACK, W_IP
  } state_t;

  state_t      state_q, state_d;

  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic        bva_valid_q, bva_valid_d;
  logic [31:0] bva_q, bva_d;
  logic        exl_q, exl_d;
  logic [31:0] epc_q, epc_d;
  logic        erl_q, erl_d;
  logic [5:0]  irq_q, irq_d;

  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_rd_q, wr_rd_d;
  logic [2:0]  wr_sel_q, wr_sel_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] wr_mask_q, wr_mask_d;
  logic        exc_ack_q, exc_ack_d;
  logic        eret_ack_q, eret_ack_d;
  logic        busy_q, busy_d;

  logic [31:0] epc_calc;
  logic        irq_changed;
  logic        unused_in;

  assign epc_calc    = exc_bd ? (exc_pc - 32'(EPC_BD_OFFSET)) : exc_pc;
  assign irq_changed = (hw_irq != cause_in[15:10]);
  assign unused_in   = ^{status_in[31:3], status_in[0], cause_in[31:16], cause_in[9:0]};

  // Next state and request latches; latches only move on acceptance in IDLE.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    bd_d        = bd_q;
    bva_valid_d = bva_valid_q;
    bva_d       = bva_q;
    exl_d       = exl_q;
    epc_d       = epc_q;
    erl_d       = erl_q;
    irq_d       = irq_q;
    unique case (state_q)
      IDLE: begin
        if (exc_valid) begin
          code_d      = exc_code;
          bd_d        = exc_bd;
          bva_valid_d = exc_bva_valid;
          bva_d       = exc_bva;
          exl_d       = status_in[1];
          epc_d       = epc_calc;
          if (exc_bva_valid)     state_d = W_BVA;
          else if (status_in[1]) state_d = W_CAUSE;
          else                   state_d = W_EPC;
        end else if (eret_valid) begin
          erl_d   = status_in[2];
          state_d = W_ERET;
        end else if (irq_changed) begin
          irq_d   = hw_irq;
          state_d = W_IP;
        end
      end
      W_BVA:    state_d = exl_q ? W_CAUSE : W_EPC;
      W_EPC:    state_d = W_CAUSE;
      W_CAUSE:  state_d = W_STATUS;
      W_STATUS: state_d = EXC_ACK;
      EXC_ACK:  state_d = IDLE;
      W_ERET:   state_d = ERET_ACK;
      ERET_ACK: state_d = IDLE;
      W_IP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode for the state being entered, using the latch values it will see.
  always_comb begin
    wr_en_d    = 1'b0;
    wr_rd_d    = 5'd0;
    wr_sel_d   = 3'd0;
    wr_data_d  = 32'd0;
    wr_mask_d  = 32'd0;
    exc_ack_d  = 1'b0;
    eret_ack_d = 1'b0;
    busy_d     = (state_d != IDLE);
    unique case (state_d)
      W_BVA: begin
        wr_en_d   = 1'b1;
        wr_rd_d   = RD_BADVADDR;
        wr_data_d = bva_d;
        wr_mask_d = 32'hFFFF_FFFF;
      end
      W_EPC: begin
        wr_en_d   = 1'b1;
        wr_rd_d   = RD_EPC;
        wr_data_d = epc_d;
        wr_mask_d = 32'hFFFF_FFFF;
      end
      W_CAUSE: begin
        wr_en_d   = 1'b1;
        wr_rd_d   = RD_CAUSE;
        wr_data_d = {bd_d, 24'd0, code_d, 2'b00};
        wr_mask_d = exl_d ? 32'h0000_007C : 32'h8000_007C;
      end
      W_STATUS: begin
        wr_en_d   = 1'b1;
        wr_rd_d   = RD_STATUS;
        wr_data_d = 32'h0000_0002;
        wr_mask_d = 32'h0000_0002;
      end
      EXC_ACK: exc_ack_d = 1'b1;
      W_ERET: begin
        wr_en_d   = 1'b1;
        wr_rd_d   = RD_STATUS;
        wr_data_d = 32'd0;
        wr_mask_d = erl_d ? 32'h0000_0004 : 32'h0000_0002;
      end
      ERET_ACK: eret_ack_d = 1'b1;
      W_IP: begin
        wr_en_d   = 1'b1;
        wr_rd_d   = RD_CAUSE;
        wr_data_d = {16'd0, irq_d, 10'd0};
        wr_mask_d = 32'h0000_FC00;
      end
      default: ;
    endcase
  end

  // State, latches and registered outputs; reset aborts any sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      code_q      <= 5'd0;
      bd_q        <= 1'b0;
      bva_valid_q <= 1'b0;
      bva_q       <= 32'd0;
      exl_q       <= 1'b0;
      epc_q       <= 32'd0;
      erl_q       <= 1'b0;
      irq_q       <= 6'd0;
      wr_en_q     <= 1'b0;
      wr_rd_q     <= 5'd0;
      wr_sel_q    <= 3'd0;
      wr_data_q   <= 32'd0;
      wr_mask_q   <= 32'd0;
      exc_ack_q   <= 1'b0;
      eret_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      bd_q        <= bd_d;
      bva_valid_q <= bva_valid_d;
      bva_q       <= bva_d;
      exl_q       <= exl_d;
      epc_q       <= epc_d;
      erl_q       <= erl_d;
      irq_q       <= irq_d;
      wr_en_q     <= wr_en_d;
      wr_rd_q     <= wr_rd_d;
      wr_sel_q    <= wr_sel_d;
      wr_data_q   <= wr_data_d;
      wr_mask_q   <= wr_mask_d;
      exc_ack_q   <= exc_ack_d;
      eret_ack_q  <= eret_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_rd    = wr_rd_q;
  assign wr_sel   = wr_sel_q;
  assign wr_data  = wr_data_q;
  assign wr_mask  = wr_mask_q;
  assign exc_ack  = exc_ack_q;
  assign eret_ack = eret_ack_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_cop0_hw_writer.sv
// Directed bench for cop0_hw_writer; outputs sampled on the falling edge.
module tb_cop0_hw_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        exc_bva_valid;
  logic [31:0] exc_bva;
  logic        exc_ack;
  logic        eret_valid;
  logic        eret_ack;
  logic [31:0] status_in;
  logic [31:0] cause_in;
  logic [5:0]  hw_irq;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;
  logic [31:0] wr_mask;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cop0_hw_writer #(.EPC_BD_OFFSET(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_bva_valid(exc_bva_valid), .exc_bva(exc_bva), .exc_ack(exc_ack),
    .eret_valid(eret_valid), .eret_ack(eret_ack),
    .status_in(status_in), .cause_in(cause_in), .hw_irq(hw_irq),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_sel(wr_sel), .wr_data(wr_data),
    .wr_mask(wr_mask), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {wr_en, exc_ack, eret_ack, busy, wr_rd, wr_sel, wr_data, wr_mask} flattened
  function automatic logic [75:0] snap();
    return {wr_en, exc_ack, eret_ack, busy, wr_rd, wr_sel, wr_data, wr_mask};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic exp_write(input string tag, input logic [4:0] rd,
                           input logic [31:0] data, input logic [31:0] mask);
    check({tag, ".ctl"}, 64'({wr_en, exc_ack, eret_ack, busy, wr_rd, wr_sel}),
          64'({1'b1, 1'b0, 1'b0, 1'b1, rd, 3'd0}));
    check({tag, ".data"}, 64'(wr_data), 64'(data));
    check({tag, ".mask"}, 64'(wr_mask), 64'(mask));
  endtask

  task automatic exp_ctl(input string tag, input logic en, input logic ea,
                         input logic ra, input logic bz);
    check(tag, 64'({wr_en, exc_ack, eret_ack, busy}), 64'({en, ea, ra, bz}));
  endtask

  initial begin
    rst_n = 1'b0; exc_valid = 0; exc_code = 0; exc_pc = 0; exc_bd = 0;
    exc_bva_valid = 0; exc_bva = 0; eret_valid = 0; status_in = 0;
    cause_in = 0; hw_irq = 0;
    repeat (3) cyc();
    check("reset.all", 64'(snap()), 64'd0);
    check("reset.hi", 64'(snap() >> 64), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("idle.all", 64'(snap()), 64'd0);
      check("idle.hi", 64'(snap() >> 64), 64'd0);
    end

    // Full exception: BadVAddr, EPC, Cause, Status, ack at cycle 5.
    exc_valid = 1; exc_code = 5'h04; exc_pc = 32'h8000_1008; exc_bd = 1;
    exc_bva_valid = 1; exc_bva = 32'h0000_0003; status_in = 32'h0;
    cyc(); exp_write("e1.bva", 5'd8, 32'h0000_0003, 32'hFFFF_FFFF);
    cyc(); exp_write("e1.epc", 5'd14, 32'h8000_1004, 32'hFFFF_FFFF);
    cyc(); exp_write("e1.cause", 5'd13, 32'h8000_0010, 32'h8000_007C);
    cyc(); exp_write("e1.status", 5'd12, 32'h0000_0002, 32'h0000_0002);
    cyc(); exp_ctl("e1.ack", 1'b0, 1'b1, 1'b0, 1'b1);
    exc_valid = 0;
    cyc(); exp_ctl("e1.after", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); exp_ctl("e1.quiet", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset asserted while in W_EPC clears outputs without a clock edge.
    exc_valid = 1;
    cyc(); exp_write("r.bva", 5'd8, 32'h0000_0003, 32'hFFFF_FFFF);
    cyc(); exp_write("r.epc", 5'd14, 32'h8000_1004, 32'hFFFF_FFFF);
    #2 rst_n = 1'b0;
    #1 check("r.async", 64'(snap()), 64'd0);
    check("r.async.hi", 64'(snap() >> 64), 64'd0);
    exc_valid = 0;
    cyc(); rst_n = 1'b1;
    cyc(); exp_ctl("r.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // EXL already set, no BadVAddr: Cause, Status, ack at cycle 3.
    exc_valid = 1; exc_bva_valid = 0; status_in = 32'h0000_0002;
    cyc(); exp_write("e2.cause", 5'd13, 32'h8000_0010, 32'h0000_007C);
    cyc(); exp_write("e2.status", 5'd12, 32'h0000_0002, 32'h0000_0002);
    cyc(); exp_ctl("e2.ack", 1'b0, 1'b1, 1'b0, 1'b1);
    exc_valid = 0;
    cyc(); exp_ctl("e2.after", 1'b0, 1'b0, 1'b0, 1'b0);

    // ERET with ERL set clears ERL; with only EXL set clears EXL.
    eret_valid = 1; status_in = 32'h0000_0006;
    cyc(); exp_write("r1.status", 5'd12, 32'h0, 32'h0000_0004);
    cyc(); exp_ctl("r1.ack", 1'b0, 1'b0, 1'b1, 1'b1);
    eret_valid = 0;
    cyc(); exp_ctl("r1.after", 1'b0, 1'b0, 1'b0, 1'b0);
    eret_valid = 1; status_in = 32'h0000_0002;
    cyc(); exp_write("r2.status", 5'd12, 32'h0, 32'h0000_0002);
    cyc(); exp_ctl("r2.ack", 1'b0, 1'b0, 1'b1, 1'b1);
    eret_valid = 0;
    cyc(); exp_ctl("r2.after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Simultaneous exception and ERET: exception first, ERET after the ack.
    exc_valid = 1; eret_valid = 1; exc_code = 5'h0C; exc_pc = 32'h0040_0020;
    exc_bd = 0; exc_bva_valid = 0; status_in = 32'h0;
    cyc(); exp_write("s.epc", 5'd14, 32'h0040_0020, 32'hFFFF_FFFF);
    cyc(); exp_write("s.cause", 5'd13, 32'h0000_0030, 32'h8000_007C);
    cyc(); exp_write("s.status", 5'd12, 32'h0000_0002, 32'h0000_0002);
    cyc(); exp_ctl("s.eack", 1'b0, 1'b1, 1'b0, 1'b1);
    exc_valid = 0;
    cyc(); exp_ctl("s.gap", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); exp_write("s.eret", 5'd12, 32'h0, 32'h0000_0002);
    cyc(); exp_ctl("s.rack", 1'b0, 1'b0, 1'b1, 1'b1);
    eret_valid = 0;
    cyc(); exp_ctl("s.after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Interrupt-pending update: one Cause write, none once cause_in follows.
    hw_irq = 6'b100001; cause_in = 32'h0;
    cyc(); exp_write("ip.cause", 5'd13, 32'h0000_8400, 32'h0000_FC00);
    cause_in = 32'h0000_8400;
    for (int i = 0; i < 5; i++) begin
      cyc(); exp_ctl("ip.quiet", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
